// File: rtl/ps2_transmisor.sv
`default_nettype none
// ============================================================================
// Module   : ps2_transmisor
// Purpose  : Host-to-device PS/2 command transmitter (RTS, 9 bits, stop, ACK)
// Revision : 1.0 - initial release
// ============================================================================
module ps2_transmisor #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       reloj,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       tx_busy,
    output logic       tx_done_tick,
    output logic       tx_err_tick
);

    localparam int MAX_CNT = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int FLT_W   = $clog2(FILTER_LEN + 1);

    localparam logic [CNT_W-1:0] C_INHIBIT_LOAD = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FLT_W-1:0] C_FILT_LAST    = FLT_W'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RTS_CLK,
        S_RTS_DAT,
        S_START,
        S_DATA,
        S_STOP,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    // Line conditioning: index 0 = clock line, index 1 = data line
    logic [1:0]       w_raw;
    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       filt_q, filt_d;
    logic [FLT_W-1:0] fcnt_q [2];
    logic [FLT_W-1:0] fcnt_d [2];
    logic             fall_tick_q, fall_tick_d;

    assign w_raw = {ps2d_in, ps2c_in};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            filt_d[i] = filt_q[i];
            fcnt_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == C_FILT_LAST) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + 1'b1;
                end
            end
        end
        fall_tick_d = filt_q[0] & ~filt_d[0];
    end

    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            filt_q      <= 2'b11;
            fcnt_q[0]   <= '0;
            fcnt_q[1]   <= '0;
            fall_tick_q <= 1'b0;
        end else begin
            sync1_q     <= w_raw;
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            fcnt_q[0]   <= fcnt_d[0];
            fcnt_q[1]   <= fcnt_d[1];
            fall_tick_q <= fall_tick_d;
        end
    end

    // Transmit control
    state_t           state_q, state_d;
    logic [8:0]       sh_q, sh_d;
    logic [3:0]       n_q, n_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             d_oe_q, d_oe_d;
    logic             ack_q, ack_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            d_oe_q  <= 1'b0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            d_oe_q  <= d_oe_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        d_oe_d  = d_oe_q;
        ack_d   = ack_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                d_oe_d = 1'b0;
                if (wr_ps2) begin
                    sh_d    = {~^din, din};
                    n_d     = '0;
                    cnt_d   = C_INHIBIT_LOAD;
                    state_d = S_RTS_CLK;
                end
            end
            S_RTS_CLK: begin
                if (cnt_q == '0) begin
                    state_d = S_RTS_DAT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RTS_DAT: begin
                d_oe_d  = 1'b1;
                ack_d   = 1'b0;
                cnt_d   = C_TIMEOUT_LOAD;
                state_d = S_START;
            end
            default: begin
                // Expiry is checked first so it overrides a coincident ACK edge
                if (cnt_q == '0) begin
                    d_oe_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    case (state_q)
                        S_START, S_DATA: begin
                            if (fall_tick_q) begin
                                d_oe_d  = ~sh_q[0];
                                sh_d    = {1'b0, sh_q[8:1]};
                                n_d     = n_q + 1'b1;
                                state_d = (n_q == 4'd8) ? S_STOP : S_DATA;
                            end
                        end
                        S_STOP: begin
                            if (fall_tick_q) begin
                                d_oe_d  = 1'b0;
                                state_d = S_ACK;
                            end
                        end
                        S_ACK: begin
                            if (fall_tick_q) begin
                                ack_d   = ~filt_q[1];
                                state_d = S_WAIT_IDLE;
                            end
                        end
                        default: begin
                            if (filt_q == 2'b11) begin
                                done_d  = ack_q;
                                err_d   = ~ack_q;
                                state_d = S_IDLE;
                            end
                        end
                    endcase
                end
            end
        endcase
    end

    // The start bit is asserted directly from RTS_DAT so data is low before the clock is released
    assign ps2c_oe      = (state_q == S_RTS_CLK) || (state_q == S_RTS_DAT);
    assign ps2d_oe      = d_oe_q || (state_q == S_RTS_DAT);
    assign tx_busy      = (state_q != S_IDLE);
    assign tx_done_tick = done_q;
    assign tx_err_tick  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_transmisor.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_transmisor
// Purpose  : Self-checking bench with a PS/2 device model and frame scoreboard
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_transmisor;

    localparam int INH  = 20;
    localparam int TMO  = 2000;
    localparam int FLT  = 4;
    localparam int HALF = 40;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       wr_ps2 = 1'b0;
    logic [7:0] din    = 8'h00;
    logic       dev_c  = 1'b1;
    logic       dev_d  = 1'b1;
    logic       glitch = 1'b0;
    logic       ps2c_in, ps2d_in;
    logic       ps2c_oe, ps2d_oe, tx_busy, tx_done_tick, tx_err_tick;

    // Open-drain wiring: either side may pull a line low
    assign ps2c_in = ~ps2c_oe & (dev_c ^ glitch);
    assign ps2d_in = ~ps2d_oe & dev_d;

    ps2_transmisor #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .FILTER_LEN    (FLT)
    ) dut (
        .reloj       (clk),
        .reset       (rst_n),
        .wr_ps2      (wr_ps2),
        .din         (din),
        .ps2c_in     (ps2c_in),
        .ps2d_in     (ps2d_in),
        .ps2c_oe     (ps2c_oe),
        .ps2d_oe     (ps2d_oe),
        .tx_busy     (tx_busy),
        .tx_done_tick(tx_done_tick),
        .tx_err_tick (tx_err_tick)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int done_cnt = 0;
    int err_cnt  = 0;
    always @(negedge clk) begin
        if (tx_done_tick) done_cnt++;
        if (tx_err_tick)  err_cnt++;
    end

    logic [10:0] exp_q[$];
    bit          out_q[$];
    int          checks = 0;
    int          errors = 0;
    int          done_base = 0;
    int          err_base  = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected line sequence as the device sees it: start, d0..d7, odd parity, stop
    function automatic logic [10:0] frame_model(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, (ones % 2 == 0), b, 1'b0};
    endfunction

    task automatic start_frame(input logic [7:0] b, input bit ok, input bit push_frame);
        done_base = done_cnt;
        err_base  = err_cnt;
        @(negedge clk);
        check_value("busy_before_wr", {31'd0, tx_busy}, 32'd0);
        din    = b;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
        din    = ~b;
        check_value("busy_rise", {31'd0, tx_busy}, 32'd1);
        if (push_frame) exp_q.push_back(frame_model(b));
        out_q.push_back(ok);
    endtask

    task automatic dev_release(output int t_dat);
        int   hc   = 0;
        logic dprv = 1'b0;
        t_dat = cyc;
        while (ps2c_oe === 1'b1 && hc < 1000) begin
            dprv  = ps2d_oe;
            t_dat = cyc;
            hc++;
            @(negedge clk);
        end
        check_value("inhibit_len", hc, INH + 1);
        check_value("start_before_release", {31'd0, dprv}, 32'd1);
        repeat (30) @(negedge clk);
    endtask

    task automatic dev_bit(input int k, input bit do_ack, input bit glitch_en, output logic seen);
        if (k == 10) dev_d = do_ack ? 1'b0 : 1'b1;
        repeat (10) @(negedge clk);
        dev_c = 1'b0;
        for (int i = 0; i < HALF; i++) begin
            glitch = glitch_en && (i == 15 || i == 16);
            @(negedge clk);
        end
        glitch = 1'b0;
        seen   = ps2d_in;
        dev_c  = 1'b1;
        for (int i = 0; i < HALF; i++) begin
            glitch = glitch_en && (i == 15 || i == 16);
            @(negedge clk);
        end
        glitch = 1'b0;
        if (k == 10) dev_d = 1'b1;
    endtask

    task automatic finish_frame(input string tag);
        int n = 0;
        bit ok;
        while (tx_busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_value({tag, "_busy_fall"}, {31'd0, tx_busy}, 32'd0);
        repeat (3) @(negedge clk);
        ok = out_q.pop_front();
        check_value({tag, "_done_pulses"}, done_cnt - done_base, ok ? 1 : 0);
        check_value({tag, "_err_pulses"},  err_cnt - err_base,   ok ? 0 : 1);
        check_value({tag, "_lines_released"}, {30'd0, ps2c_oe, ps2d_oe}, 32'd0);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b, input bit ack, input bit glitch_en);
        int          t;
        logic        s;
        logic [10:0] got = '0;
        logic [10:0] exp;
        start_frame(b, ack, 1'b1);
        dev_release(t);
        got[0] = ps2d_in;
        for (int k = 0; k <= 10; k++) begin
            dev_bit(k, ack, glitch_en, s);
            if (k < 10) got[k+1] = s;
        end
        exp = exp_q.pop_front();
        check_value({tag, "_frame_bits"}, {21'd0, got}, {21'd0, exp});
        finish_frame(tag);
    endtask

    initial begin
        int          t_dat;
        int          n;
        int          diff;
        logic        s;
        logic [10:0] got;
        logic [10:0] exp;
        bit          dummy;

        repeat (3) @(negedge clk);
        check_value("reset_outputs",
                    {27'd0, ps2c_oe, ps2d_oe, tx_busy, tx_done_tick, tx_err_tick}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        run_frame("ed_ack", 8'hED, 1'b1, 1'b0);
        run_frame("f4_ack", 8'hF4, 1'b1, 1'b0);
        run_frame("00_nack", 8'h00, 1'b0, 1'b0);

        // Device never clocks: only the timeout can end the frame
        start_frame(8'hA5, 1'b0, 1'b0);
        dev_release(t_dat);
        n = 0;
        while (!tx_err_tick && n < 3000) begin
            @(negedge clk);
            n++;
        end
        diff = cyc - t_dat;
        if (!(diff >= TMO - 1 && diff <= TMO + 1))
            $display("timeout observed %0d cycles after RTS_DAT", diff);
        check_value("timeout_window", {31'd0, (diff >= TMO - 1 && diff <= TMO + 1)}, 32'd1);
        finish_frame("timeout");

        run_frame("ed_glitch", 8'hED, 1'b1, 1'b1);

        // Abort mid-frame with reset; a busy-time request must not start anything
        got = '0;
        start_frame(8'hED, 1'b1, 1'b1);
        dev_release(t_dat);
        got[0] = ps2d_in;
        for (int k = 0; k < 4; k++) begin
            dev_bit(k, 1'b1, 1'b0, s);
            got[k+1] = s;
            if (k == 1) begin
                @(negedge clk);
                wr_ps2 = 1'b1;
                din    = 8'h00;
                @(negedge clk);
                wr_ps2 = 1'b0;
            end
        end
        repeat (10) @(negedge clk);
        dev_c = 1'b0;
        repeat (20) @(negedge clk);
        check_value("bit4_driven_low", {31'd0, ps2d_oe}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_value("async_reset_release", {29'd0, ps2c_oe, ps2d_oe, tx_busy}, 32'd0);
        dev_c = 1'b1;
        dev_d = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        exp = exp_q.pop_front();
        check_value("partial_bits", {27'd0, got[4:0]}, {27'd0, exp[4:0]});
        dummy = out_q.pop_front();
        repeat (100) @(negedge clk);
        check_value("no_stray_frame", {30'd0, ps2c_oe, tx_busy}, 32'd0);
        check_value("reset_no_pulses", (done_cnt - done_base) + (err_cnt - err_base), 0);

        run_frame("55_after_reset", 8'h55, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
